ahb_gb_master: RTL and testbench
================================

Name: ahb_gb_master

Overview:
- Bridges the access point's generic-bus request (ren/wen/addr/wdata/byte_en, replies busy/rdata) onto a single-master AHB-Lite bus in the AFT_CLK domain.
- Sits directly downstream of the AHB access point. It issues one non-pipelined SINGLE transfer per request.
- Reports completion, bus errors and stalled-slave timeouts back to the AP.

Parameters:
- HPROT_VAL, 4'b0011, constant HPROT driven on every transfer (data, privileged).
- TIMEOUT_CYCLES, 256, max data-phase cycles before abort; 0 disables the timeout.

Ports:
- AFT_CLK  in  1  clock
- nRST  in  1  reset
- ren  in  1  read request; held until busy=0
- wen  in  1  write request; held until busy=0
- addr  in  32  byte address
- wdata  in  32  write data, already lane-aligned
- byte_en  in  4  lane enables; 4'b0000 means byte access
- rdata  out  32  read data; valid while busy=0 after a read
- busy  out  1  high except in the completion (DONE) cycle
- error  out  1  high in the DONE cycle if HRESP error or timeout
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- HWRITE  out  1
- HADDR  out  32
- HSIZE  out  3
- HBURST  out  3  always 3'b000 (SINGLE)
- HPROT  out  4  = HPROT_VAL
- HWDATA  out  32
- HRDATA  in  32
- HREADY  in  1
- HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset: nRST, asynchronous, active-low; clock AFT_CLK. On reset, all outputs take these values:
  - state=IDLE, HTRANS=IDLE, HWRITE=0, HADDR=0, HSIZE=0, HWDATA=0
  - rdata=0, busy=1, error=0, timeout counter=0
- Reset mid-transfer abandons the transfer immediately, with no completion pulse.

FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If wen|ren, latch a request: dir (wen has priority if both are set), addr, wdata, and the decoded size/offset. Then go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - Drive HTRANS=NONSEQ, HWRITE=dir, HADDR=latched address, HSIZE.
  - If HREADY=1, the address phase is accepted; go to DATA. If HREADY=0, hold all outputs.
- DATA:
  - HTRANS=IDLE. HWDATA=latched wdata for writes.
  - Timeout counter increments each cycle.
  - HREADY=1 & HRESP=0: capture HRDATA into rdata (reads only; writes leave rdata unchanged), error_n=0, go to DONE.
  - HREADY=1 & HRESP=1: error_n=1, rdata unchanged, go to DONE.
  - HRESP=1 with HREADY=0 (first error cycle): stay in DATA.
  - Counter reaches TIMEOUT_CYCLES (when nonzero): error_n=1, go to DONE. Any late slave response is ignored.
- DONE:
  - busy=0; error=registered error_n.
  - Always go to IDLE next. A request still held in IDLE is treated as a new transfer.
  - The AP must drop ren/wen after sampling busy=0.

Latency: zero-wait transfer = 4 cycles from request to the DONE cycle (IDLE, ADDR, DATA, DONE). Each HREADY=0 cycle adds 1 cycle.

Size/offset decode, done once at latch time:
- byte_en 1111: HSIZE=010, HADDR[1:0]=00.
- byte_en 0011: HSIZE=001, HADDR[1:0]=00.
- byte_en 1100: HSIZE=001, HADDR[1:0]=10.
- One-hot byte_en: HSIZE=000, HADDR[1:0]=index of the set bit.
- byte_en 0000: HSIZE=000, HADDR[1:0]=addr[1:0].
- Any other pattern: HSIZE=010, HADDR[1:0]=00.
- HADDR[31:2]=addr[31:2] in all cases.

Other rules:
- rdata is raw HRDATA with no lane shifting; the AP extracts lanes.
- Request inputs are ignored outside IDLE; changes mid-transfer have no effect.
- Timeout counter clears on entry to ADDR and saturates at TIMEOUT_CYCLES. Its width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1.

Decomposition:
- jtag_types_pkg additions:
  - ahb_gb_state_t enum (IDLE, ADDR, DATA, DONE)
  - HTRANS_IDLE / HTRANS_NONSEQ constants
  - HSIZE_BYTE / HSIZE_HALF / HSIZE_WORD constants
  - HBURST_SINGLE constant
- Sub-module ahb_size_decode: combinational map from byte_en and addr[1:0] to HSIZE and HADDR[1:0]. Reusable by later AP variants.

Test Plan:
- Word write, zero wait:
  - Stimulus: wen=1, addr=0x2000_0010, wdata=0xDEAD_BEEF, byte_en=1111, HREADY=1.
  - Response: ADDR cycle shows NONSEQ/HWRITE=1/HSIZE=010/HADDR=0x2000_0010. Next cycle HWDATA=0xDEAD_BEEF. busy=0 on the 4th cycle with error=0.
- Byte read with byte_en=0000:
  - Stimulus: ren=1, addr=0x1000_0003, HRDATA=0xAABB_CCDD.
  - Response: HSIZE=000, HADDR=0x1000_0003, rdata=0xAABB_CCDD in the DONE cycle.
- Wait states:
  - Stimulus: half read, byte_en=1100, addr=0x40. HREADY=0 for 1 ADDR cycle and 3 DATA cycles.
  - Response: HADDR=0x42, HSIZE=001, outputs stable while stalled. DONE at cycle 8; busy stays high until then.
- Error response:
  - Stimulus: write; slave returns HRESP=1/HREADY=0, then HRESP=1/HREADY=1.
  - Response: DONE with error=1, HTRANS=IDLE throughout the data phase, rdata unchanged.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, HREADY held 0 in DATA.
  - Response: DONE with error=1 exactly 8 DATA cycles after entry. A following ren starts a fresh ADDR phase.
- Reset and back-to-back:
  - Stimulus: assert nRST=0 during DATA; later hold wen across DONE.
  - Response: on reset, outputs immediately return to reset values with no busy=0 pulse. After reset, a held wen produces a second complete transfer.

Source files
------------

// File: rtl/jtag_types_pkg.sv
// ----------------------------------------------------------------------------
// jtag_types_pkg
// Shared types and constants for the debug access path. This slice carries the
// pieces used by the AHB generic-bus master: its FSM state type and the AHB-Lite
// encodings it drives.
// ----------------------------------------------------------------------------
package jtag_types_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10,
        S_DONE = 2'b11
    } ahb_gb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/ahb_size_decode.sv
// ----------------------------------------------------------------------------
// ahb_size_decode
// Maps the AP's lane enables onto an AHB transfer size and the low two address
// bits. byte_en 0000 denotes a byte access addressed by addr[1:0]; patterns
// that are not a naturally aligned byte/half/word fall back to a word access.
// Ports:
//   i_byte_en  [3:0]  lane enables from the request
//   i_addr_lo  [1:0]  request address bits [1:0]
//   o_hsize    [2:0]  AHB HSIZE
//   o_addr_lo  [1:0]  HADDR[1:0] to drive
// ----------------------------------------------------------------------------
module ahb_size_decode
    import jtag_types_pkg::*;
(
    input  logic [3:0] i_byte_en,
    input  logic [1:0] i_addr_lo,
    output logic [2:0] o_hsize,
    output logic [1:0] o_addr_lo
);

    always_comb begin
        o_hsize   = HSIZE_WORD;
        o_addr_lo = 2'b00;
        case (i_byte_en)
            4'b1111: begin o_hsize = HSIZE_WORD; o_addr_lo = 2'b00;     end
            4'b0011: begin o_hsize = HSIZE_HALF; o_addr_lo = 2'b00;     end
            4'b1100: begin o_hsize = HSIZE_HALF; o_addr_lo = 2'b10;     end
            4'b0001: begin o_hsize = HSIZE_BYTE; o_addr_lo = 2'b00;     end
            4'b0010: begin o_hsize = HSIZE_BYTE; o_addr_lo = 2'b01;     end
            4'b0100: begin o_hsize = HSIZE_BYTE; o_addr_lo = 2'b10;     end
            4'b1000: begin o_hsize = HSIZE_BYTE; o_addr_lo = 2'b11;     end
            4'b0000: begin o_hsize = HSIZE_BYTE; o_addr_lo = i_addr_lo; end
            default: begin o_hsize = HSIZE_WORD; o_addr_lo = 2'b00;     end
        endcase
    end

endmodule

// File: rtl/ahb_gb_master.sv
// ----------------------------------------------------------------------------
// ahb_gb_master
// Bridges the access point's generic-bus request onto a single-master AHB-Lite
// bus. Each request becomes one non-pipelined SINGLE transfer:
// IDLE -> ADDR (NONSEQ until HREADY) -> DATA (until HREADY or timeout) -> DONE.
// busy drops for exactly the DONE cycle; error qualifies that cycle.
// Ports:
//   AFT_CLK, nRST            clock, async active-low reset
//   ren, wen                 request strobes (wen wins), held until busy=0
//   addr, wdata, byte_en     request payload, sampled only in IDLE
//   rdata, busy, error       AP completion interface
//   HTRANS..HWDATA           AHB-Lite master outputs
//   HRDATA, HREADY, HRESP    AHB-Lite slave response
// ----------------------------------------------------------------------------
module ahb_gb_master
    import jtag_types_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL      = 4'b0011,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic        AFT_CLK,
    input  logic        nRST,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        error,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HADDR,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0]   CNT_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);

    ahb_gb_state_t    r_state;
    ahb_gb_state_t    w_state_nxt;
    logic             r_dir;
    logic [31:0]      r_haddr;
    logic [2:0]       r_hsize;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_latch;
    logic             w_cap;
    logic             w_err_d;
    logic             w_timeout;
    logic [CNT_W:0]   w_cnt_inc;
    logic [2:0]       w_hsize;
    logic [1:0]       w_addr_lo;

    ahb_size_decode u_size_decode (
        .i_byte_en (byte_en),
        .i_addr_lo (addr[1:0]),
        .o_hsize   (w_hsize),
        .o_addr_lo (w_addr_lo)
    );

    // Timeout fires on the data-phase cycle in which the count would reach
    // the limit, so the abort lands exactly TIMEOUT_CYCLES cycles into DATA.
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_timeout = TO_EN && (w_cnt_inc >= CNT_LIM);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cap       = 1'b0;
        w_err_d     = r_err;
        case (r_state)
            S_IDLE: begin
                if (wen || ren) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                // A real slave response on the limit cycle still wins over
                // the timeout.
                if (HREADY) begin
                    w_state_nxt = S_DONE;
                    w_err_d     = HRESP;
                    w_cap       = !HRESP && !r_dir;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                    w_err_d     = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge AFT_CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_haddr <= '0;
            r_hsize <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_d;
            if (w_latch) begin
                r_dir   <= wen;
                r_haddr <= {addr[31:2], w_addr_lo};
                r_hsize <= w_hsize;
                r_wdata <= wdata;
                r_cnt   <= '0;
            end else if (r_state == S_DATA && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_cap) r_rdata <= HRDATA;
        end
    end

    assign HTRANS = (r_state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE = (r_state == S_ADDR) && r_dir;
    assign HADDR  = r_haddr;
    assign HSIZE  = r_hsize;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_VAL;
    assign HWDATA = r_wdata;
    assign rdata  = r_rdata;
    assign busy   = (r_state != S_DONE);
    assign error  = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_ahb_gb_master.sv
// ----------------------------------------------------------------------------
// tb_ahb_gb_master
// Transaction-level reference: each transfer is described by its request and
// the slave's stall/error plan; the expected bus phase of every cycle and the
// completion values follow from that plan. One compare process checks the DUT
// every cycle; directed cases also pin literal values.
// ----------------------------------------------------------------------------
module tb_ahb_gb_master;

    localparam int TO = 8;

    logic        AFT_CLK = 1'b0;
    logic        nRST    = 1'b0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] rdata;
    logic        busy, error;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP  = 1'b0;

    ahb_gb_master #(.HPROT_VAL(4'b0011), .TIMEOUT_CYCLES(TO)) dut (
        .AFT_CLK(AFT_CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .rdata(rdata), .busy(busy),
        .error(error), .HTRANS(HTRANS), .HWRITE(HWRITE), .HADDR(HADDR),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 AFT_CLK = ~AFT_CLK;

    int checks = 0;
    int failures = 0;

    // expected phase per cycle: 0 idle, 1 address, 2 data, 3 completion
    logic        chk_en = 1'b0;
    int          exp_ph = 0;
    logic        exp_write = 1'b0;
    logic [31:0] exp_haddr = '0;
    logic [2:0]  exp_hsize = '0;
    logic [31:0] exp_hwdata = '0;
    logic        exp_error = 1'b0;
    logic [31:0] model_rdata = '0;
    int          cyc_idx = 0;

    logic [31:0] rec_haddr, rec_hwdata, rec_rdata;
    logic [2:0]  rec_hsize;
    logic        rec_err;
    int          rec_done_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Size/offset rule: aligned word/half, single byte lane, 0000 = byte at addr.
    function automatic logic [4:0] model_decode(input logic [3:0] be, input logic [1:0] lo);
        logic [1:0] idx;
        idx = 2'd0;
        if (be == 4'b1111)            return {3'b010, 2'b00};
        if (be == 4'b0011)            return {3'b001, 2'b00};
        if (be == 4'b1100)            return {3'b001, 2'b10};
        if (be == 4'b0000)            return {3'b000, lo};
        if ($countones(be) == 1) begin
            for (int i = 0; i < 4; i++) if (be[i]) idx = 2'(i);
            return {3'b000, idx};
        end
        return {3'b010, 2'b00};
    endfunction

    always @(negedge AFT_CLK) begin
        if (chk_en) begin
            chk("hprot",  32'(HPROT), 32'h3);
            chk("hburst", 32'(HBURST), 32'h0);
            chk("busy",   32'(busy), 32'(exp_ph != 3));
            chk("htrans", 32'(HTRANS), (exp_ph == 1) ? 32'h2 : 32'h0);
            if (exp_ph == 1) begin
                chk("hwrite", 32'(HWRITE), 32'(exp_write));
                chk("haddr",  HADDR, exp_haddr);
                chk("hsize",  32'(HSIZE), 32'(exp_hsize));
                rec_haddr = HADDR;
                rec_hsize = HSIZE;
            end
            if (exp_ph == 2 && exp_write) begin
                chk("hwdata", HWDATA, exp_hwdata);
                rec_hwdata = HWDATA;
            end
            if (exp_ph == 3) begin
                chk("error", 32'(error), 32'(exp_error));
                chk("rdata", rdata, model_rdata);
                rec_rdata    = rdata;
                rec_err      = error;
                rec_done_idx = cyc_idx;
            end else begin
                chk("error_idle", 32'(error), 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge AFT_CLK);
        #1;
        cyc_idx++;
    endtask

    task automatic scramble();
        addr    = $urandom;
        wdata   = $urandom;
        byte_en = 4'($urandom);
    endtask

    task automatic idle(input int n);
        ren = 1'b0; wen = 1'b0; exp_ph = 0;
        repeat (n) step();
    endtask

    // One transfer: astall address-phase waits, dstall data-phase waits.
    // More than TO-1 data waits means the slave never answers in time.
    task automatic run_xfer(input logic dir, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input int astall, input int dstall,
                            input bit err, input logic [31:0] hr, input bit hold);
        logic [4:0] d;
        bit timed;
        int ndata;
        d = model_decode(be, a[1:0]);
        timed = (dstall + 1 > TO);
        ndata = timed ? TO : dstall + 1;
        cyc_idx = 1;
        wen = dir; ren = dir ? 1'($urandom) : 1'b1;
        addr = a; wdata = wd; byte_en = be;
        HREADY = 1'($urandom); HRESP = 1'b0;
        exp_ph = 0;
        exp_write = dir; exp_haddr = {a[31:2], d[1:0]}; exp_hsize = d[4:2]; exp_hwdata = wd;
        step();
        for (int i = 0; i <= astall; i++) begin
            exp_ph = 1;
            HREADY = (i == astall); HRESP = 1'b0;
            scramble();
            step();
        end
        for (int i = 0; i < ndata; i++) begin
            exp_ph = 2;
            HREADY = !timed && (i == ndata - 1);
            HRESP  = !timed && err && (i >= ndata - 2);
            HRDATA = HREADY ? hr : $urandom;
            scramble();
            step();
        end
        exp_ph = 3;
        exp_error = err || timed;
        if (!dir && !err && !timed) model_rdata = hr;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        step();
        exp_ph = 0;
        if (!hold) begin ren = 1'b0; wen = 1'b0; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_busy",   32'(busy), 32'h1);
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr",  HADDR, 32'h0);
        chk("rst_rdata",  rdata, 32'h0);
        chk("rst_error",  32'(error), 32'h0);
        @(negedge AFT_CLK);
        nRST = 1'b1;
        @(posedge AFT_CLK); #1;
        chk_en = 1'b1;
        idle(2);

        // word write, zero wait
        run_xfer(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 0, 1'b0, 32'h0, 1'b0);
        chk("lit_w_haddr", rec_haddr, 32'h2000_0010);
        chk("lit_w_hsize", 32'(rec_hsize), 32'h2);
        chk("lit_w_hwdata", rec_hwdata, 32'hDEAD_BEEF);
        chk("lit_w_latency", 32'(rec_done_idx), 32'd4);
        chk("lit_w_err", 32'(rec_err), 32'h0);
        idle(1);

        // byte read, byte_en 0000
        run_xfer(1'b0, 32'h1000_0003, 32'h0, 4'b0000, 0, 0, 1'b0, 32'hAABB_CCDD, 1'b0);
        chk("lit_b_haddr", rec_haddr, 32'h1000_0003);
        chk("lit_b_hsize", 32'(rec_hsize), 32'h0);
        chk("lit_b_rdata", rec_rdata, 32'hAABB_CCDD);
        idle(1);

        // half read with wait states
        run_xfer(1'b0, 32'h0000_0040, 32'h0, 4'b1100, 1, 3, 1'b0, 32'h1234_5678, 1'b0);
        chk("lit_h_haddr", rec_haddr, 32'h0000_0042);
        chk("lit_h_hsize", 32'(rec_hsize), 32'h1);
        chk("lit_h_latency", 32'(rec_done_idx), 32'd8);
        idle(1);

        // error response on a write: rdata keeps the last read
        run_xfer(1'b1, 32'h3000_0000, 32'h5555_AAAA, 4'b1111, 0, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("lit_e_err", 32'(rec_err), 32'h1);
        chk("lit_e_rdata", rec_rdata, 32'h1234_5678);
        idle(1);

        // timeout, then a fresh read
        run_xfer(1'b0, 32'h4000_0004, 32'h0, 4'b1111, 0, 30, 1'b0, 32'h0, 1'b0);
        chk("lit_t_err", 32'(rec_err), 32'h1);
        chk("lit_t_latency", 32'(rec_done_idx), 32'd11);
        chk("lit_t_rdata", rec_rdata, 32'h1234_5678);
        run_xfer(1'b0, 32'h4000_0008, 32'h0, 4'b1111, 0, 0, 1'b0, 32'h0BAD_F00D, 1'b0);
        chk("lit_t2_latency", 32'(rec_done_idx), 32'd4);
        chk("lit_t2_rdata", rec_rdata, 32'h0BAD_F00D);
        idle(1);

        // reset in the data phase
        chk_en = 1'b0;
        wen = 1'b1; ren = 1'b0; addr = 32'h5000_0000; wdata = 32'h1111_2222; byte_en = 4'hF;
        HREADY = 1'b1;
        step();
        HREADY = 1'b1;
        step();
        HREADY = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_busy",   32'(busy), 32'h1);
        chk("mid_rst_htrans", 32'(HTRANS), 32'h0);
        chk("mid_rst_hwrite", 32'(HWRITE), 32'h0);
        chk("mid_rst_haddr",  HADDR, 32'h0);
        chk("mid_rst_hsize",  32'(HSIZE), 32'h0);
        chk("mid_rst_hwdata", HWDATA, 32'h0);
        chk("mid_rst_rdata",  rdata, 32'h0);
        chk("mid_rst_error",  32'(error), 32'h0);
        wen = 1'b0;
        @(posedge AFT_CLK); #1;
        chk("mid_rst_busy2", 32'(busy), 32'h1);
        @(negedge AFT_CLK);
        nRST = 1'b1;
        model_rdata = '0;
        @(posedge AFT_CLK); #1;
        chk_en = 1'b1;
        idle(1);

        // back-to-back with wen held across completion
        run_xfer(1'b1, 32'h6000_0010, 32'hCAFE_0001, 4'b0011, 0, 0, 1'b0, 32'h0, 1'b1);
        run_xfer(1'b1, 32'h6000_0010, 32'hCAFE_0001, 4'b0011, 0, 0, 1'b0, 32'h0, 1'b0);
        chk("lit_bb_latency", 32'(rec_done_idx), 32'd4);
        chk("lit_bb_hwdata", rec_hwdata, 32'hCAFE_0001);
        idle(1);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [3:0] be;
            int sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: be = 4'b1111;
                1: be = 4'b0011;
                2: be = 4'b1100;
                3: be = 4'b0001 << $urandom_range(0, 3);
                4: be = 4'b0000;
                default: be = 4'($urandom);
            endcase
            run_xfer(1'($urandom), $urandom, $urandom, be,
                     $urandom_range(0, 2), $urandom_range(0, 10),
                     ($urandom_range(0, 4) == 0), $urandom, 1'($urandom));
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
